// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_pkg
// Purpose  : Shared encodings for the data-memory access master.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int c_DATA_W    = 32;
    localparam int c_MEM_DEPTH = 3101;

    // Request size encodings; 2'b11 is reserved and reported as an error.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        RESP = 2'b11
    } state_t;

endpackage : mem_access_pkg
`default_nettype wire

// File: rtl/mem_lane_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_unit
// Purpose  : Combinational little-endian lane extract/extend and lane merge.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic [1:0]        i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_sign,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_ext_data,
    output logic [DATA_W-1:0] o_merged_data
);

    logic [4:0]  w_byte_shift;
    logic [4:0]  w_half_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Half lanes only ever start at bit 0 or bit 16.
    assign w_byte_shift = {i_lane, 3'b000};
    assign w_half_shift = {i_lane[1], 4'b0000};
    assign w_byte       = i_rdata[w_byte_shift +: 8];
    assign w_half       = i_rdata[w_half_shift +: 16];

    always_comb begin
        o_ext_data    = i_rdata;
        o_merged_data = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_ext_data = {{(DATA_W-8){i_sign & w_byte[7]}}, w_byte};
                o_merged_data = i_rdata;
                o_merged_data[w_byte_shift +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_ext_data = {{(DATA_W-16){i_sign & w_half[15]}}, w_half};
                o_merged_data = i_rdata;
                o_merged_data[w_half_shift +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule : mem_lane_unit
`default_nettype wire

// File: rtl/mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master
// Purpose  : CPU load/store initiator to a word-indexed data memory, with
//            range/alignment checks and read-modify-write sub-word stores.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int MEM_DEPTH = c_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [DATA_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemReadData
);

    state_t            r_state;
    state_t            w_next_state;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_lane;
    logic [DATA_W-1:0] r_wdata;

    logic              w_accept;
    logic              w_word_store;
    logic              w_bad_size;
    logic              w_misaligned;
    logic              w_out_of_range;
    logic              w_err;
    logic [DATA_W-1:0] w_index;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_merged;

    assign req_ready    = (r_state == IDLE) && !reset;
    assign w_accept     = req_valid && req_ready;
    assign w_index      = req_addr >> 2;
    assign w_word_store = req_we && (req_size == SZ_WORD);

    assign w_bad_size     = (req_size == 2'b11);
    assign w_misaligned   = ((req_size == SZ_HALF) && req_addr[0])
                          || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_out_of_range = (w_index >= DATA_W'(MEM_DEPTH));
    assign w_err          = w_bad_size || w_misaligned || w_out_of_range;

    mem_lane_unit #(
        .DATA_W        (DATA_W)
    ) u_lane (
        .i_lane        (r_lane),
        .i_size        (r_size),
        .i_sign        (r_signed),
        .i_rdata       (MemReadData),
        .i_wdata       (r_wdata),
        .o_ext_data    (w_ext),
        .o_merged_data (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Strobes decode purely from the registered state, never from req_*.
    always_comb begin
        w_next_state = r_state;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_next_state = RESP;
                    end else if (w_word_store) begin
                        w_next_state = WR;
                    end else begin
                        w_next_state = RD;
                    end
                end
            end
            RD: begin
                MemRead      = 1'b1;
                w_next_state = r_we ? WR : RESP;
            end
            WR: begin
                MemWrite     = 1'b1;
                w_next_state = RESP;
            end
            RESP: begin
                resp_valid   = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_lane       <= 2'b00;
            r_wdata      <= '0;
            MemAddress   <= '0;
            MemWriteData <= '0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_signed   <= req_signed;
                        r_lane     <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        MemAddress <= w_index;
                        resp_rdata <= '0;
                        resp_err   <= w_err;
                        if (w_word_store) begin
                            MemWriteData <= req_wdata;
                        end
                    end
                end
                RD: begin
                    // Sub-word stores reuse the read to build the merged word.
                    if (r_we) begin
                        MemWriteData <= w_merged;
                    end else begin
                        resp_rdata <= w_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : mem_access_master
`default_nettype wire

// File: tb/tb_mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_master
// Purpose  : Table-driven, scoreboarded bench for mem_access_master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_master;
    import mem_access_pkg::*;

    localparam int c_DEPTH = 3101;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    always #5 clk = ~clk;

    mem_access_master dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    // Behavioural data memory with a bench-side preload port.
    logic [31:0] mem [0:c_DEPTH-1];
    logic        tb_wr_en = 1'b0;
    logic [31:0] tb_wr_idx = '0;
    logic [31:0] tb_wr_data = '0;

    assign MemReadData = (MemAddress < 32'(c_DEPTH)) ? mem[MemAddress[11:0]] : 32'h0;

    always @(posedge clk) begin
        if (tb_wr_en) begin
            mem[tb_wr_idx[11:0]] <= tb_wr_data;
        end else if (MemWrite && (MemAddress < 32'(c_DEPTH))) begin
            mem[MemAddress[11:0]] <= MemWriteData;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd_at;
        int          exp_wr_at;
        logic [31:0] exp_mem;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pre,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                       input int exp_rd_at, input int exp_wr_at, input logic [31:0] exp_mem);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata; v.pre = pre;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        v.exp_rd_at = exp_rd_at; v.exp_wr_at = exp_wr_at; v.exp_mem = exp_mem;
        vecs.push_back(v);
    endtask

    task automatic preload(input logic [31:0] idx, input logic [31:0] data);
        @(negedge clk);
        tb_wr_en   = 1'b1;
        tb_wr_idx  = idx;
        tb_wr_data = data;
        @(posedge clk);
        #1 tb_wr_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [31:0] idx;
        logic        in_range;
        int          rd_at;
        int          wr_at;
        logic [31:0] wr_data;
        logic        done;
        exp_t        e;
        idx      = v.addr >> 2;
        in_range = (idx < 32'(c_DEPTH));
        if (in_range) preload(idx, v.pre);
        @(negedge clk);
        check($sformatf("v%0d ready_idle", id), {31'b0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat});
        @(posedge clk);
        #1;
        // Scramble the request bus to show fields were captured at accept.
        req_valid  = 1'b0;
        req_we     = ~v.we;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = ~v.sgn;
        req_addr   = $urandom;
        req_wdata  = $urandom;
        rd_at = 0; wr_at = 0; wr_data = '0; done = 1'b0;
        for (int k = 1; k <= 8 && !done; k++) begin
            @(negedge clk);
            check($sformatf("v%0d rd_wr_exclusive", id), {31'b0, MemRead & MemWrite}, 32'h0);
            if (MemRead && rd_at == 0) begin
                rd_at = k;
                check($sformatf("v%0d rd_addr", id), MemAddress, idx);
            end
            if (MemWrite && wr_at == 0) begin
                wr_at   = k;
                wr_data = MemWriteData;
                check($sformatf("v%0d wr_addr", id), MemAddress, idx);
            end
            if (resp_valid) begin
                done = 1'b1;
                check($sformatf("v%0d sb_nonempty", id), sb.size(), 32'h1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check($sformatf("v%0d rdata", id), resp_rdata, e.rdata);
                    check($sformatf("v%0d err", id), {31'b0, resp_err}, {31'b0, e.err});
                    check($sformatf("v%0d latency", id), k, e.lat);
                end
                check($sformatf("v%0d ready_in_resp", id), {31'b0, req_ready}, 32'h0);
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d timeout: got no resp_valid within 8 cycles, required one", id);
            sb.delete();
        end
        check($sformatf("v%0d rd_cycle", id), rd_at, v.exp_rd_at);
        check($sformatf("v%0d wr_cycle", id), wr_at, v.exp_wr_at);
        if (v.exp_wr_at != 0) check($sformatf("v%0d wr_data", id), wr_data, v.exp_mem);
        @(negedge clk);
        check($sformatf("v%0d ready_after", id), {31'b0, req_ready}, 32'h1);
        if (in_range) check($sformatf("v%0d mem_after", id), mem[idx[11:0]], v.exp_mem);
    endtask

    initial begin : main
        int hits;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;

        //   we  size     sgn  addr        wdata         pre           rdata         err lat rd wr mem
        add(0, SZ_WORD, 0, 32'h14,   32'h0,        32'h8899AABB, 32'h8899AABB, 0, 2, 1, 0, 32'h8899AABB);
        add(0, SZ_BYTE, 1, 32'h17,   32'h0,        32'h8899AABB, 32'hFFFFFF88, 0, 2, 1, 0, 32'h8899AABB);
        add(0, SZ_BYTE, 0, 32'h17,   32'h0,        32'h8899AABB, 32'h00000088, 0, 2, 1, 0, 32'h8899AABB);
        add(0, SZ_BYTE, 1, 32'h15,   32'h0,        32'h8899AABB, 32'hFFFFFFAA, 0, 2, 1, 0, 32'h8899AABB);
        add(0, SZ_BYTE, 1, 32'h14,   32'h0,        32'h8899AABB, 32'hFFFFFFBB, 0, 2, 1, 0, 32'h8899AABB);
        add(0, SZ_BYTE, 0, 32'h16,   32'h0,        32'h8899AABB, 32'h00000099, 0, 2, 1, 0, 32'h8899AABB);
        add(0, SZ_HALF, 1, 32'h16,   32'h0,        32'h8899AABB, 32'hFFFF8899, 0, 2, 1, 0, 32'h8899AABB);
        add(0, SZ_HALF, 0, 32'h14,   32'h0,        32'h8899AABB, 32'h0000AABB, 0, 2, 1, 0, 32'h8899AABB);
        add(0, SZ_WORD, 1, 32'h14,   32'h0,        32'h8899AABB, 32'h8899AABB, 0, 2, 1, 0, 32'h8899AABB);
        add(1, SZ_HALF, 0, 32'h16,   32'h00001234, 32'h8899AABB, 32'h0,        0, 3, 1, 2, 32'h1234AABB);
        add(1, SZ_BYTE, 0, 32'h15,   32'hFFFFFF5A, 32'h8899AABB, 32'h0,        0, 3, 1, 2, 32'h88995ABB);
        add(1, SZ_WORD, 0, 32'h20,   32'hDEADBEEF, 32'h00000000, 32'h0,        0, 2, 0, 1, 32'hDEADBEEF);
        add(0, SZ_HALF, 1, 32'h15,   32'h0,        32'h8899AABB, 32'h0,        1, 1, 0, 0, 32'h8899AABB);
        add(0, SZ_WORD, 0, 32'h12,   32'h0,        32'h8899AABB, 32'h0,        1, 1, 0, 0, 32'h8899AABB);
        add(0, 2'b11,   0, 32'h14,   32'h0,        32'h8899AABB, 32'h0,        1, 1, 0, 0, 32'h8899AABB);
        add(0, SZ_WORD, 0, 32'h30D4, 32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
        add(0, SZ_WORD, 0, 32'h3070, 32'h0,        32'h13572468, 32'h13572468, 0, 2, 1, 0, 32'h13572468);
        add(1, SZ_WORD, 0, 32'h3074, 32'h11111111, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0);
        add(1, SZ_WORD, 0, 32'h16,   32'hFFFFFFFF, 32'h8899AABB, 32'h0,        1, 1, 0, 0, 32'h8899AABB);
        add(1, SZ_HALF, 0, 32'h17,   32'h0000FFFF, 32'h8899AABB, 32'h0,        1, 1, 0, 0, 32'h8899AABB);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ready", {31'b0, req_ready}, 32'h0);
        check("rst resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rst rdata", resp_rdata, 32'h0);
        check("rst err", {31'b0, resp_err}, 32'h0);
        check("rst MemAddress", MemAddress, 32'h0);
        check("rst MemWriteData", MemWriteData, 32'h0);
        check("rst strobes", {30'b0, MemRead, MemWrite}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("rst ready_after", {31'b0, req_ready}, 32'h1);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Reset during the RD cycle of a sub-word store.
        preload(32'd5, 32'h8899AABB);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_HALF; req_signed = 1'b0;
        req_addr = 32'h16; req_wdata = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("midrst in_rd", {31'b0, MemRead}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst ready", {31'b0, req_ready}, 32'h1);
        check("midrst MemWriteData", MemWriteData, 32'h0);
        check("midrst MemAddress", MemAddress, 32'h0);
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            if (MemWrite || MemRead || resp_valid) hits++;
            @(negedge clk);
        end
        check("midrst no_activity", hits, 32'h0);
        check("midrst mem", mem[5], 32'h8899AABB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_access_master
`default_nettype wire
